id_ex_stage: RTL and testbench

- ID/EX pipeline register for the pipelined CPU; captures register-file read data (rd1/rd2), decoded fields and control from decode, and presents them to execute.
- Contains load-use hazard detection (stall upstream, inject bubble) and EX-stage operand forwarding from EX/MEM and MEM/WB.
- Register file writes on negedge, so same-cycle WB->ID is already write-first; this block forwards only to the operands it holds.

---
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the pipelined CPU.
//   Latches decode outputs (register-file read data, decoded fields, control)
//   and presents them to execute. Detects load-use hazards, which stall the
//   upstream stages and inject a bubble. Forwards EX/MEM and MEM/WB results
//   into the held operands.
// Ports:
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   id_*                decode-stage instruction, fields, read data and control
//   flush               kill the decode slot (branch/jump redirect)
//   ex_hold             downstream stall; freeze this register
//   exm_*, wb_*         EX/MEM and MEM/WB write-back info for forwarding
//   stall               freeze PC and IF/ID (combinational)
//   ex_*                latched execute-stage state; ex_op_a/b are forwarded
//   fwd_a, fwd_b        operand source select: 0 reg, 1 EX/MEM, 2 MEM/WB
// Optional build macro HAZARD_STATS_EN adds the saturating counters
//   stall_cnt[15:0] and bubble_cnt[15:0].
module id_ex_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              exm_reg_write,
  input  logic [4:0]        exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic            lu;

  // Load-use hazard: the load in EX produces a register the decode slot reads.
  // Outputs are forced quiet while reset is held.
  always_comb begin
    lu    = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
            ((ex_rd == id_rs) || (ex_rd == id_rt));
    stall = rst_n && ((lu && !flush) || ex_hold);
  end

  // Operand forwarding; EX/MEM is the younger result so it takes precedence.
  always_comb begin
    fwd_a   = 2'd0;
    fwd_b   = 2'd0;
    ex_op_a = ex_rd1;
    ex_op_b = ex_rd2;
    if (!rst_n) begin
      ex_op_a = '0;
      ex_op_b = '0;
    end else begin
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_rs)) begin
        fwd_a   = 2'd1;
        ex_op_a = exm_result;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
        fwd_a   = 2'd2;
        ex_op_a = wb_data;
      end
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_rt)) begin
        fwd_b   = 2'd1;
        ex_op_b = exm_result;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt)) begin
        fwd_b   = 2'd2;
        ex_op_b = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (ex_hold) begin
      // freeze everything
    end else if (flush || lu) begin
      // Bubble: only the qualifiers clear; data fields hold (don't-care).
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rd1       <= id_rd1;
      ex_rd2       <= id_rd2;
      ex_imm       <= id_imm;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_ctrl      <= id_ctrl;
      ex_mem_read  <= id_mem_read && id_valid;
      ex_reg_write <= id_reg_write && id_valid;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!ex_hold) begin
      if (lu && !flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
      if ((lu || flush) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage. Expected execute-stage
// snapshots are pushed to a scoreboard queue as stimulus is driven and popped
// and compared once the DUT should present them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [7:0]  id_ctrl;
  logic        id_mem_read, id_reg_write;
  logic        flush, ex_hold;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_data;
  logic        stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, bubble_cnt;
`endif

  typedef struct packed {
    logic        valid;
    logic        mr;
    logic        rw;
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t sb[$];
  exp_t last, got, want;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage #(.CTRL_W(8), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .flush(flush), .ex_hold(ex_hold), .exm_reg_write(exm_reg_write),
    .exm_rd(exm_rd), .exm_result(exm_result), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sample();
    exp_t s;
    s.valid = ex_valid;   s.mr = ex_mem_read; s.rw = ex_reg_write;
    s.pc = ex_pc;         s.op_a = ex_op_a;   s.op_b = ex_op_b;
    s.imm = ex_imm;       s.rs = ex_rs;       s.rt = ex_rt;
    s.rd = ex_rd;         s.ctrl = ex_ctrl;   s.fa = fwd_a;
    s.fb = fwd_b;
    return s;
  endfunction

  // Model of what a normal load of the current decode slot produces (no forwarding).
  function automatic exp_t exp_from_id();
    exp_t e;
    e.valid = id_valid;   e.mr = id_mem_read & id_valid;
    e.rw = id_reg_write & id_valid;
    e.pc = id_pc;         e.op_a = id_rd1;    e.op_b = id_rd2;
    e.imm = id_imm;       e.rs = id_rs;       e.rt = id_rt;
    e.rd = id_rd;         e.ctrl = id_ctrl;   e.fa = 2'd0;
    e.fb = 2'd0;
    return e;
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic mr, input logic rw);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = a; id_rd2 = b; id_imm = pc ^ 32'h0000_5A5A;
    id_ctrl = {rd, 3'b101}; id_mem_read = mr; id_reg_write = rw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_hold = 1'b1;
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b1, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", stall);
    end
    last = '0;
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", got, want);
    end
    ex_hold = 1'b0;
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b0, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL basic_latch: got %h want %h", got, want);
    end
  endtask

  task automatic test_load_use();
    // load r5, then consumer reading r5 via rs
    set_id(1'b1, 32'h200, 5'd6, 5'd7, 5'd5, 32'h61, 32'h71, 1'b1, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL lu_load: got %h want %h", got, want);
    end
    set_id(1'b1, 32'h204, 5'd5, 5'd8, 5'd9, 32'h91, 32'h92, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b want 1", stall);
    end
    last.valid = 1'b0; last.mr = 1'b0; last.rw = 1'b0;
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL lu_bubble: got %h want %h", got, want);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall_release: got %b want 0", stall);
    end
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL lu_retry: got %h want %h", got, want);
    end
    // load to r0 followed by reader of r0: no hazard
    set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd0, 32'h31, 32'h32, 1'b1, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL lu_r0_load: got %h want %h", got, want);
    end
    set_id(1'b1, 32'h304, 5'd0, 5'd0, 5'd4, 32'h41, 32'h42, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_r0_stall: got %b want 0", stall);
    end
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL lu_r0_next: got %h want %h", got, want);
    end
  endtask

  task automatic test_forwarding();
    set_id(1'b1, 32'h400, 5'd4, 5'd7, 5'd10, 32'h44, 32'h77, 1'b0, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL fwd_latch: got %h want %h", got, want);
    end
    set_id(1'b0, 32'h404, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    exm_reg_write = 1'b1; exm_rd = 5'd4; exm_result = 32'hAA;
    wb_reg_write = 1'b1;  wb_rd = 5'd4;  wb_data = 32'hBB;
    #1;
    last.op_a = 32'hAA; last.fa = 2'd1;
    sb.push_back(last);
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL fwd_exm_wins: got %h want %h", got, want);
    end
    exm_reg_write = 1'b0;
    #1;
    last.op_a = 32'hBB; last.fa = 2'd2;
    sb.push_back(last);
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL fwd_wb: got %h want %h", got, want);
    end
    exm_reg_write = 1'b1; exm_rd = 5'd7;
    #1;
    last.op_b = 32'hAA; last.fb = 2'd1;
    sb.push_back(last);
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL fwd_both_ops: got %h want %h", got, want);
    end
    // instruction reading r0 with writers targeting r0: no forwarding
    set_id(1'b1, 32'h408, 5'd0, 5'd0, 5'd11, 32'h55, 32'h66, 1'b0, 1'b1);
    exm_rd = 5'd0; wb_rd = 5'd0;
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL fwd_r0: got %h want %h", got, want);
    end
    exm_reg_write = 1'b0; wb_reg_write = 1'b0;
  endtask

  task automatic test_flush();
    set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd5, 32'h51, 32'h52, 1'b1, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL flush_load: got %h want %h", got, want);
    end
    set_id(1'b1, 32'h504, 5'd5, 5'd3, 5'd6, 32'h53, 32'h54, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b want 0", stall);
    end
    last.valid = 1'b0; last.mr = 1'b0; last.rw = 1'b0;
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL flush_kill: got %h want %h", got, want);
    end
    flush = 1'b0;
  endtask

  task automatic test_hold();
    set_id(1'b1, 32'h600, 5'd8, 5'd9, 5'd12, 32'h81, 32'h82, 1'b0, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL hold_latch: got %h want %h", got, want);
    end
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
             $urandom, $urandom, 1'b0, 1'b1);
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL hold_stall[%0d]: got %b want 1", i, stall);
      end
      sb.push_back(last);
      tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: got %h want %h", i, got, want);
      end
    end
    ex_hold = 1'b0;
    set_id(1'b1, 32'h700, 5'd13, 5'd14, 5'd15, 32'hD1, 32'hD2, 1'b0, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL hold_release: got %h want %h", got, want);
    end
  endtask

  task automatic test_reset_mid();
    // generate some hazard activity first so counters are non-zero
    set_id(1'b1, 32'h800, 5'd1, 5'd2, 5'd7, 32'hE1, 32'hE2, 1'b1, 1'b1);
    last = exp_from_id();
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rmid_valid: got %h want %h", got, want);
    end
    rst_n = 1'b0;
    ex_hold = 1'b1;
    set_id(1'b1, 32'h804, 5'd7, 5'd7, 5'd8, 32'hE3, 32'hE4, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stall: got %b want 0", stall);
    end
    last = '0;
    sb.push_back(last);
    tick();
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rmid_state: got %h want %h", got, want);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if ({stall_cnt, bubble_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL rmid_counters: got %h/%h want 0/0", stall_cnt, bubble_cnt);
    end
`endif
    rst_n = 1'b1;
    ex_hold = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    wb_reg_write = 1'b0;  wb_rd = '0;  wb_data = '0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_load_use();
    test_forwarding();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
